// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   ser_state_t : serializer FSM states (S_IDLE, S_START, S_DATA, S_STOP)
//   cnt_width() : counter width for a modulus, never below one bit
package uart_arb_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   // $clog2 of 1 is 0, which would give a zero-width vector.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART serializer, LSB first. A byte presented with load while idle is copied
// internally; the line drops to the start bit on the next cycle.
// Ports:
//   clk         in   system clock
//   reset_rtl_0 in   asynchronous active-high reset (line returns high at once)
//   load        in   accept data this cycle (ignored unless idle)
//   data[7:0]   in   byte to send
//   busy        out  a frame is being shifted
//   txd         out  serial line, idle high
module uart_tx_serializer
   import uart_arb_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_rtl_0,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       txd
);

   localparam int unsigned    CntW    = cnt_width(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      LastBit = 3'(UART_DATA_BITS - 1);

   ser_state_t      state_q, state_d;
   logic [CntW-1:0] baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            txd_q, txd_d;

   logic bit_end;
   assign bit_end = (baud_q == CntMax);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      txd_d   = txd_q;
      unique case (state_q)
         S_IDLE: begin
            if (load) begin
               state_d = S_START;
               baud_d  = '0;
               bit_d   = '0;
               shreg_d = data;
               txd_d   = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_DATA;
               txd_d   = shreg_q[0];
               shreg_d = shreg_q >> 1;
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == LastBit) begin
                  state_d = S_STOP;
                  txd_d   = UART_IDLE_LEVEL;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  txd_d   = shreg_q[0];
                  shreg_d = shreg_q >> 1;
               end
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_rtl_0) begin
      if (reset_rtl_0) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         txd_q   <= UART_IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign txd  = txd_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit line among NUM_REQ byte-stream requesters. Ownership is
// granted round-robin and held for a whole message (until a byte with req_last), so
// frames from different requesters never interleave. A silent owner loses the grant
// after TIMEOUT_CYCLES.
// Ports:
//   clk          in   system clock
//   reset_rtl_0  in   asynchronous active-high reset
//   req_valid    in   per-requester byte valid
//   req_data     in   byte for requester i at [8*i+7:8*i]
//   req_last     in   byte ends its message
//   req_ready    out  byte accepted when valid & ready (owner only, while not busy)
//   grant        out  one-hot line owner, zero when unowned
//   busy         out  serializer is shifting a frame
//   uart_txd     out  serial output, idle high
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned BAUD           = 115_200,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 reset_rtl_0,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 uart_txd
);

   localparam int unsigned     CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned     IdxW   = cnt_width(NUM_REQ);
   localparam int unsigned     TmoW   = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

   arb_state_t      state_q, state_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] rr_q, rr_d;
   logic [TmoW-1:0] tmo_q, tmo_d;

   logic            owner_valid, owner_last, hs;
   logic [7:0]      owner_data;
   logic [IdxW-1:0] next_rr;
   logic            pick_found;
   logic [IdxW-1:0] pick_idx;
   int unsigned     scan_idx;

   assign owner_valid = req_valid[owner_q];
   assign owner_last  = req_last[owner_q];
   assign owner_data  = req_data[8*owner_q +: 8];
   assign hs          = (state_q == LOCKED) && owner_valid && !busy;
   assign next_rr     = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_idx = (32'(rr_q) + i) % NUM_REQ;
         if (!pick_found && req_valid[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = IdxW'(scan_idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = LOCKED;
               owner_d = pick_idx;
               tmo_d   = '0;
            end
         end
         LOCKED: begin
            if (hs) begin
               tmo_d = '0;
               if (owner_last) begin
                  state_d = IDLE;
                  rr_d    = next_rr;
               end
            end else if (!owner_valid) begin
               // Silent owner: give the line up; a frame in flight still completes.
               if (tmo_q == TmoMax) begin
                  state_d = IDLE;
                  rr_d    = next_rr;
                  tmo_d   = '0;
               end else begin
                  tmo_d = tmo_q + TmoW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_rtl_0) begin
      if (reset_rtl_0) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         tmo_q   <= tmo_d;
      end
   end

   assign grant     = (state_q == LOCKED) ? (NUM_REQ'(1) << owner_q) : '0;
   assign req_ready = grant & {NUM_REQ{!busy}};

   uart_tx_serializer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk        (clk),
      .reset_rtl_0(reset_rtl_0),
      .load       (hs),
      .data       (owner_data),
      .busy       (busy),
      .txd        (uart_txd)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with 4 clocks per bit and a 32-cycle timeout.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_rtl_0;
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [15:0] req_data;
   logic        busy, uart_txd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ       (2),
      .CLK_HZ        (400),
      .BAUD          (100),
      .TIMEOUT_CYCLES(32)
   ) dut (
      .clk        (clk),
      .reset_rtl_0(reset_rtl_0),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .grant      (grant),
      .busy       (busy),
      .uart_txd   (uart_txd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Called on the cycle after a handshake; walks the 40 line cycles of one frame.
   task automatic capture(input string name, input logic [9:0] exp_frame);
      logic [9:0] f;
      int         nbusy;
      bit         stable;
      f      = '0;
      nbusy  = 0;
      stable = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c % 4 == 0) f[c/4] = uart_txd;
         else if (uart_txd !== f[c/4]) stable = 1'b0;
         if (busy) nbusy++;
         tick();
      end
      check({name, " frame"}, 32'(f), 32'(exp_frame));
      check({name, " bit_stable"}, 32'(stable), 32'd1);
      check({name, " busy_cycles"}, 32'(nbusy), 32'd40);
      check({name, " busy_drop"}, 32'(busy), 32'd0);
   endtask

   // Ownership rules, sampled away from the active edge.
   always @(negedge clk) begin
      if (reset_rtl_0 === 1'b0) begin
         total++;
         if (!$onehot0(grant) || ((req_ready & ~grant) != 2'b00) ||
             (busy && (req_ready != 2'b00))) begin
            bad++;
            $display("FAIL ownership: grant=%b ready=%b busy=%b", grant, req_ready, busy);
         end
      end
   end

   typedef struct {
      int         r;
      logic [7:0] data;
      logic [1:0] exp_grant;
      logic [9:0] exp_frame;
   } vec_t;

   vec_t vecs[4];

   // Both requesters post a one-byte message from IDLE; requester 0 must win first.
   task automatic two_req(input string name);
      req_valid = 2'b11;
      req_data  = {8'hB1, 8'hA0};
      req_last  = 2'b11;
      tick();
      check({name, " first_grant"}, 32'(grant), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      check({name, " release0"}, 32'(grant), 32'h0);
      capture({name, " A0"}, 10'b1101000000);
      check({name, " second_grant"}, 32'(grant), 32'h2);
      check({name, " second_ready"}, 32'(req_ready), 32'h2);
      tick();
      req_valid[1] = 1'b0;
      check({name, " release1"}, 32'(grant), 32'h0);
      capture({name, " B1"}, 10'b1101100010);
   endtask

   initial begin
      vecs[0] = '{r: 0, data: 8'h55, exp_grant: 2'b01, exp_frame: 10'b1010101010};
      vecs[1] = '{r: 1, data: 8'h3C, exp_grant: 2'b10, exp_frame: 10'b1001111000};
      vecs[2] = '{r: 0, data: 8'hFF, exp_grant: 2'b01, exp_frame: 10'b1111111110};
      vecs[3] = '{r: 1, data: 8'h81, exp_grant: 2'b10, exp_frame: 10'b1100000010};

      reset_rtl_0 = 1'b1;
      req_valid   = '0;
      req_last    = '0;
      req_data    = '0;
      #1;
      check("reset txd", 32'(uart_txd), 32'd1);
      check("reset grant", 32'(grant), 32'd0);
      check("reset ready", 32'(req_ready), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_rtl_0 = 1'b0;
      tick();
      check("idle grant", 32'(grant), 32'd0);

      // Single-byte messages from one requester at a time.
      for (int i = 0; i < 4; i++) begin
         req_valid[vecs[i].r]          = 1'b1;
         req_data[8*vecs[i].r +: 8]    = vecs[i].data;
         req_last[vecs[i].r]           = 1'b1;
         tick();
         check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_grant));
         tick();
         req_valid = '0;
         check($sformatf("vec%0d release", i), 32'(grant), 32'd0);
         check($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
         capture($sformatf("vec%0d", i), vecs[i].exp_frame);
      end

      two_req("rr_a");
      two_req("rr_b");

      // Three-byte message from requester 0 while requester 1 waits.
      req_valid = 2'b11;
      req_data  = {8'h77, 8'h01};
      req_last  = 2'b10;
      tick();
      check("msg grant", 32'(grant), 32'h1);
      tick();
      req_data[7:0] = 8'h02;
      capture("msg b0", 10'b1000000010);
      check("msg b2b ready1", 32'(req_ready), 32'h1);
      tick();
      req_data[7:0] = 8'h03;
      req_last[0]   = 1'b1;
      capture("msg b1", 10'b1000000100);
      check("msg b2b ready2", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      check("msg release", 32'(grant), 32'h0);
      capture("msg b2", 10'b1000000110);
      check("msg next grant", 32'(grant), 32'h2);
      check("msg next ready", 32'(req_ready), 32'h2);
      tick();
      req_valid[1] = 1'b0;
      capture("msg req1", 10'b1011101110);

      // Requester 1 goes silent mid-message and loses the grant.
      req_valid = 2'b10;
      req_data  = {8'h11, 8'h22};
      req_last  = 2'b00;
      tick();
      check("tmo grant", 32'(grant), 32'h2);
      tick();
      req_valid = 2'b01;
      req_last  = 2'b01;
      repeat (31) tick();
      check("tmo held at 31", 32'(grant), 32'h2);
      tick();
      check("tmo released at 32", 32'(grant), 32'h0);
      tick();
      check("tmo regrant", 32'(grant), 32'h1);
      req_valid[1] = 1'b1;
      req_last[1]  = 1'b1;
      repeat (7) tick();
      check("tmo frame done", 32'(busy), 32'd0);
      check("tmo late req1 no ready", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      capture("tmo req0", 10'b1001000100);
      check("tmo rearb grant", 32'(grant), 32'h2);
      check("tmo rearb ready", 32'(req_ready), 32'h2);
      tick();
      req_valid[1] = 1'b0;
      capture("tmo req1", 10'b1000100010);

      // Reset during d3; pointer is 1 beforehand, must restart at 0.
      req_valid = 2'b01;
      req_data  = {8'h00, 8'hF0};
      req_last  = 2'b11;
      tick();
      check("rst pre grant", 32'(grant), 32'h1);
      tick();
      req_valid = 2'b00;
      repeat (17) tick();
      check("rst pre d3", 32'(uart_txd), 32'd0);
      check("rst pre busy", 32'(busy), 32'd1);
      req_valid = 2'b11;
      #2;
      reset_rtl_0 = 1'b1;
      #1;
      check("rst async txd", 32'(uart_txd), 32'd1);
      check("rst async grant", 32'(grant), 32'd0);
      check("rst async ready", 32'(req_ready), 32'd0);
      check("rst async busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_rtl_0 = 1'b0;
      tick();
      check("rst rr restart", 32'(grant), 32'h1);
      req_valid = 2'b00;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
